// File: rtl/axis_pkg.sv
// axis_pkg: shared stream widths, beat types and arbiter state encoding
package axis_pkg;
  localparam int WORD_W = 8;
  localparam int BUS_W = 32;
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WORDS_PER_BEAT-1:0] keep_t;
  typedef logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] beat_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// axis_packet_arbiter_rr_pick: rotate-priority picker, first request at or after ptr wins
module axis_packet_arbiter_rr_pick #(
  parameter int N_S = 2,
  localparam int SEL_W = (N_S > 1) ? $clog2(N_S) : 1,
  localparam int SW1 = SEL_W + 1
) (
  input  logic [N_S-1:0]   i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_gnt_idx,
  output logic             o_any
);
  logic [2*N_S-1:0] w_dbl;
  logic [N_S-1:0]   w_rot;
  logic [SEL_W:0]   w_sum;
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_S-1:0];
  assign o_any = |i_req;
  // scan rotated requests from the far end so the smallest offset from ptr is kept
  always_comb begin
    o_gnt_idx = '0;
    w_sum = '0;
    for (int i = N_S - 1; i >= 0; i--) begin
      w_sum = {1'b0, i_ptr} + SW1'(i);
      o_gnt_idx = w_rot[i] ? SEL_W'(w_sum >= SW1'(N_S) ? w_sum - SW1'(N_S) : w_sum) : o_gnt_idx;
    end
  end
endmodule

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-atomic round-robin AXIS merger; AXIS_ARB_STATS_EN adds pkt_cnt
module axis_packet_arbiter #(
  parameter int N_S = 2,
  parameter int WORD_W = 8,
  parameter int BUS_W = 32,
  localparam int WPB = BUS_W / WORD_W,
  localparam int SEL_W = (N_S > 1) ? $clog2(N_S) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_S-1:0]                   s_valid,
  output logic [N_S-1:0]                   s_ready,
  input  logic [N_S-1:0]                   s_last,
  input  logic [N_S-1:0][WPB-1:0]          s_keep,
  input  logic [N_S-1:0][WPB-1:0][WORD_W-1:0] s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             m_last,
  output logic [WPB-1:0]                   m_keep,
  output logic [WPB-1:0][WORD_W-1:0]       m_data,
  output logic [SEL_W-1:0]                 m_sel
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [N_S-1:0][31:0]             pkt_cnt
`endif
);
  import axis_pkg::*;
  arb_state_t r_state;
  logic [SEL_W-1:0] r_ptr, r_g, w_pick, r_m_sel;
  logic w_any, w_out_en, w_acc, w_last, r_m_valid, r_m_last;
  logic [WPB-1:0] w_keep, r_m_keep;
  logic [WPB-1:0][WORD_W-1:0] w_data, r_m_data;
  axis_packet_arbiter_rr_pick #(.N_S(N_S)) u_pick (
    .i_req(s_valid), .i_ptr(r_ptr), .o_gnt_idx(w_pick), .o_any(w_any)
  );
  assign w_out_en = !r_m_valid || m_ready;
  assign w_acc = |(s_valid & s_ready);
  // only the granted source sees ready, and only when the output register has room
  always_comb begin
    s_ready = '0;
    for (int i = 0; i < N_S; i++) s_ready[i] = (r_state == GRANT) && (r_g == SEL_W'(i)) && w_out_en;
  end
  // select the granted source's beat
  always_comb begin
    w_last = 1'b0;
    w_keep = '0;
    w_data = '0;
    for (int i = 0; i < N_S; i++) begin
      w_last = (r_g == SEL_W'(i)) ? s_last[i] : w_last;
      w_keep = (r_g == SEL_W'(i)) ? s_keep[i] : w_keep;
      w_data = (r_g == SEL_W'(i)) ? s_data[i] : w_data;
    end
  end
  // grant FSM: pick in IDLE, hold the grant until the packet's last beat is taken
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_g <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_g <= w_pick;
        r_state <= GRANT;
      end
    end else if (w_acc && w_last) begin
      r_ptr <= (r_g == SEL_W'(N_S - 1)) ? '0 : r_g + SEL_W'(1);
      r_state <= IDLE;
    end
  end
  // output register: load on accepted beat, drain when the sink takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_last <= 1'b0;
      r_m_keep <= '0;
      r_m_data <= '0;
      r_m_sel <= '0;
    end else if (w_acc) begin
      r_m_valid <= 1'b1;
      r_m_last <= w_last;
      r_m_keep <= w_keep;
      r_m_data <= w_data;
      r_m_sel <= r_g;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end
  assign m_valid = r_m_valid;
  assign m_last = r_m_last;
  assign m_keep = r_m_keep;
  assign m_data = r_m_data;
  assign m_sel = r_m_sel;
`ifdef AXIS_ARB_STATS_EN
  logic [N_S-1:0][31:0] r_pkt_cnt;
  // count packets per source as their last beat is accepted
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_S; i++)
      r_pkt_cnt[i] <= rst ? 32'd0 : r_pkt_cnt[i] + 32'(s_valid[i] && s_ready[i] && s_last[i]);
  end
  assign pkt_cnt = r_pkt_cnt;
`endif
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: scoreboard bench for the packet arbiter with three sources
module tb_axis_packet_arbiter;
  import axis_pkg::*;
  typedef struct packed {beat_t d; keep_t k; logic l;} exp_t;
  logic clk = 0, rst = 1, m_ready = 1;
  logic [2:0] s_valid, s_ready, s_last;
  logic [2:0][3:0] s_keep;
  logic [2:0][3:0][7:0] s_data;
  logic m_valid, m_last;
  logic [3:0] m_keep;
  logic [3:0][7:0] m_data;
  logic [1:0] m_sel;
`ifdef AXIS_ARB_STATS_EN
  logic [2:0][31:0] pkt_cnt;
`endif
  logic vld[3], lst[3];
  logic [3:0] kp[3];
  logic [31:0] dat[3];
  exp_t sq[3][$];
  exp_t e;
  int checks = 0, errors = 0;
  int seen[3];
  logic [31:0] order_code;
  logic in_pkt;
  logic [1:0] pkt_sel;
  axis_packet_arbiter #(.N_S(3), .WORD_W(8), .BUS_W(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_keep(s_keep), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_keep(m_keep), .m_data(m_data), .m_sel(m_sel)
`ifdef AXIS_ARB_STATS_EN
    , .pkt_cnt(pkt_cnt)
`endif
  );
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = vld[i];
      s_last[i] = lst[i];
      s_keep[i] = kp[i];
      s_data[i] = dat[i];
    end
  end
  // scoreboard monitor: pop the expected beat of the source named by m_sel
  always @(negedge clk) begin
    if (rst) begin
      in_pkt = 0;
      order_code = 0;
      for (int i = 0; i < 3; i++) seen[i] = 0;
    end else if (m_valid && m_ready) begin
      checks++;
      if (m_sel > 2) begin
        errors++;
        $display("FAIL m_sel_range got %0d need <=2", m_sel);
      end else if (in_pkt && m_sel != pkt_sel) begin
        errors++;
        $display("FAIL interleave got sel %0d need %0d", m_sel, pkt_sel);
      end else if (sq[m_sel].size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat sel=%0d data=%h", m_sel, m_data);
      end else begin
        e = sq[m_sel].pop_front();
        if ({m_data, m_keep, m_last} !== {e.d, e.k, e.l}) begin
          errors++;
          $display("FAIL beat sel=%0d got d=%h k=%h l=%b need d=%h k=%h l=%b",
                   m_sel, m_data, m_keep, m_last, e.d, e.k, e.l);
        end
      end
      in_pkt = !m_last;
      pkt_sel = m_sel;
      if (m_last && m_sel <= 2) begin
        order_code = (order_code << 4) | 32'(m_sel + 1);
        seen[m_sel]++;
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog");
  end
  task automatic do_reset();
    rst = 1;
    m_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 0; lst[i] = 0; kp[i] = 0; dat[i] = 0;
      sq[i].delete();
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic send_pkt(input int s, input int nw, input int stall, input bit kz);
    int nb = (nw + 3) / 4;
    int n;
    exp_t x;
    for (int b = 0; b < nb; b++) begin
      while ($urandom_range(99) < stall) begin
        vld[s] = 0;
        @(posedge clk); #1;
      end
      x.d = $urandom;
      x.k = (b == nb - 1 && nw % 4 != 0) ? keep_t'((1 << (nw % 4)) - 1) : 4'hF;
      if (kz && b == 1) x.k = '0;
      x.l = (b == nb - 1);
      dat[s] = x.d; kp[s] = x.k; lst[s] = x.l; vld[s] = 1;
      sq[s].push_back(x);
      n = 0;
      do begin @(negedge clk); n++; end while (!s_ready[s] && n < 5000);
      if (!s_ready[s]) begin
        checks++; errors++;
        $display("FAIL handshake_timeout src=%0d got s_ready=0 need 1", s);
        vld[s] = 0;
        return;
      end
      @(posedge clk); #1;
    end
    vld[s] = 0;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((sq[0].size() + sq[1].size() + sq[2].size()) != 0 && n < 3000) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((sq[0].size() + sq[1].size() + sq[2].size()) != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d beats outstanding need 0", name, sq[0].size() + sq[1].size() + sq[2].size());
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_valid, m_last, m_keep, m_data, m_sel, s_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b l=%b k=%h d=%h sel=%0d rdy=%b need all 0",
               m_valid, m_last, m_keep, m_data, m_sel, s_ready);
    end
  endtask
  task automatic test_single();
    do_reset();
    send_pkt(0, 12, 0, 1);
    drain("single");
    checks++;
    if (order_code !== 32'h1) begin
      errors++; $display("FAIL single_order got %h need 1", order_code);
    end
  endtask
  task automatic test_simultaneous();
    do_reset();
    fork
      begin send_pkt(0, 7, 0, 0); send_pkt(0, 4, 0, 0); end
      begin send_pkt(1, 8, 0, 0); send_pkt(1, 3, 0, 0); end
    join
    drain("simul");
    checks++;
    if (order_code !== 32'h1212) begin
      errors++; $display("FAIL simul_order got %h need 1212", order_code);
    end
  endtask
  task automatic test_no_interleave();
    do_reset();
    fork
      send_pkt(0, 20, 0, 0);
      begin repeat (2) @(posedge clk); #1; send_pkt(1, 8, 0, 0); end
      repeat (6) begin
        @(negedge clk);
        checks++;
        if (s_ready[1] !== 1'b0) begin
          errors++; $display("FAIL hold_src1_ready got %b need 0", s_ready[1]);
        end
      end
    join
    drain("interleave");
    checks++;
    if (order_code !== 32'h12) begin
      errors++; $display("FAIL interleave_order got %h need 12", order_code);
    end
  endtask
  task automatic test_backpressure();
    do_reset();
    fork
      send_pkt(0, 24, 0, 0);
      begin
        repeat (4) @(posedge clk);
        #1 m_ready = 0;
        repeat (10) begin
          @(negedge clk);
          checks++;
          if (m_valid !== 1'b1 || s_ready[0] !== 1'b0 || sq[0].size() == 0 || m_data !== sq[0][0].d) begin
            errors++;
            $display("FAIL stall got v=%b rdy=%b d=%h need v=1 rdy=0 d=%h", m_valid, s_ready[0], m_data,
                     sq[0].size() != 0 ? sq[0][0].d : 32'hx);
          end
        end
        @(posedge clk); #1 m_ready = 1;
      end
    join
    drain("backpressure");
  endtask
  task automatic test_reset_mid();
    do_reset();
    send_pkt(0, 4, 0, 0);
    drain("pre_reset");
    dat[1] = $urandom; kp[1] = 4'hF; lst[1] = 0; vld[1] = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0; vld[1] = 0;
    checks++;
    if ({m_valid, m_last, m_keep, s_ready} !== '0) begin
      errors++; $display("FAIL reset_mid got v=%b l=%b k=%h rdy=%b need all 0", m_valid, m_last, m_keep, s_ready);
    end
    fork
      send_pkt(1, 4, 0, 0);
      send_pkt(0, 4, 0, 0);
    join
    drain("post_reset");
    checks++;
    if (order_code !== 32'h12) begin
      errors++; $display("FAIL reset_ptr_order got %h need 12", order_code);
    end
  endtask
  task automatic test_random();
    bit done = 0;
    do_reset();
    fork
      begin
        fork
          for (int p = 0; p < 17; p++) send_pkt(0, $urandom_range(1, 100), 20, 0);
          for (int p = 0; p < 17; p++) send_pkt(1, $urandom_range(1, 100), 20, 0);
          for (int p = 0; p < 16; p++) send_pkt(2, $urandom_range(1, 100), 20, 0);
        join
        done = 1;
      end
      while (!done) begin
        m_ready = $urandom_range(99) >= 20;
        @(posedge clk); #1;
      end
    join
    m_ready = 1;
    drain("random");
    checks++;
    if (seen[0] != 17 || seen[1] != 17 || seen[2] != 16) begin
      errors++; $display("FAIL random_pkts got %0d/%0d/%0d need 17/17/16", seen[0], seen[1], seen[2]);
    end
`ifdef AXIS_ARB_STATS_EN
    checks++;
    if (pkt_cnt[0] + pkt_cnt[1] + pkt_cnt[2] !== 32'd50 || pkt_cnt[2] !== 32'd16) begin
      errors++; $display("FAIL pkt_cnt got %0d/%0d/%0d need sum 50", pkt_cnt[0], pkt_cnt[1], pkt_cnt[2]);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_no_interleave();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
